// File: rtl/mult_unit.sv
// Multi-cycle 32x32 shift-add multiplier owning the HI/LO registers.
// One ripple add per cycle for 32 cycles, then one cycle for sign fix-up and writeback.

module ripple_add32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[WIDTH];
endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [CW-1:0]      cnt_reg;
  logic               neg_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] result;

  ripple_add32 #(.WIDTH(WIDTH)) u_add (
    .a    (p_reg[2*WIDTH-1:WIDTH]),
    .b    (a_reg),
    .sum  (sum),
    .cout (carry)
  );

  // Magnitudes; the most negative value maps onto itself, read as unsigned 2^31.
  assign abs_a  = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
  assign abs_b  = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
  assign result = neg_reg ? (~p_reg + 1'b1) : p_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      a_reg     <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (start) begin
            neg_reg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            a_reg     <= abs_a;
            p_reg     <= {{WIDTH{1'b0}}, abs_b};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Carry-out becomes the new product MSB as the partial sum shifts right.
          if (p_reg[0])
            p_reg <= {carry, sum, p_reg[WIDTH-1:1]};
          else
            p_reg <= {1'b0, p_reg[2*WIDTH-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) state_reg <= FIX;
        end
        FIX: begin
          hi_reg    <= result[2*WIDTH-1:WIDTH];
          lo_reg    <= result[WIDTH-1:0];
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;
endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: latency, signed/unsigned products, handshake, mthi/mtlo, reset.

module tb_mult_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, is_signed, hi_we, lo_we;
  logic [31:0] op_a, op_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Called at a negedge; start is sampled on the following posedge (edge N).
  // Returns at the negedge inside cycle N+1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; is_signed = $urandom; op_a = $urandom; op_b = $urandom;
  endtask

  // Steps negedge by negedge from cycle 'first' until done; start is raised in cycles inj1/inj2.
  task automatic wait_done(input int first, input int inj1, input int inj2,
                           output int lat, output int busy_cnt);
    lat = first;
    busy_cnt = first - 1;
    while (!done && lat <= 60) begin
      if (busy) busy_cnt++;
      start = (lat == inj1 || lat == inj2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL done_timeout: done not seen by cycle %0d, required cycle 34", lat);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_unsigned_max;
    int lat, bc;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, 0, 0, lat, bc);
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL umax_latency: got %0d, required 34", lat); end
    n_checks++;
    if (bc !== 33) begin n_fail++; $display("FAIL umax_busy_cycles: got %0d, required 33", bc); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL umax_busy_at_done: got %b, required 0", busy); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL umax_product: got %h_%h, required fffffffe_00000001", hi, lo);
    end
    $display("multu ffffffff x ffffffff -> %h_%h lat=%0d busy=%0d", hi, lo, lat, bc);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL umax_done_width: done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_signed;
    logic [31:0] va [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0007};
    logic [31:0] vb [6] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFF9, 32'hFFFF_FFFA};
    logic [63:0] ex [6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
                            64'hFFFF_FFFF_0000_0000, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFD6};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, va[i], vb[i]);
      wait_done(1, 0, 0, lat, bc);
      n_checks++;
      if ({hi, lo} !== ex[i]) begin
        n_fail++;
        $display("FAIL signed_%0d: %h x %h got %h_%h, required %h", i, va[i], vb[i], hi, lo, ex[i]);
      end
      $display("mult %h x %h -> %h_%h", va[i], vb[i], hi, lo);
      @(negedge clk);
    end
  endtask

  task automatic test_handshake;
    int lat, bc, extra;
    issue(1'b0, 32'd3, 32'd4);
    wait_done(1, 5, 33, lat, bc);
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL hs_latency: got %0d, required 34", lat); end
    n_checks++;
    if (lo !== 32'd12 || hi !== 32'd0) begin n_fail++; $display("FAIL hs_product: got %h_%h, required 0000000c", hi, lo); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL hs_ignored_start: %0d extra busy/done cycles, required 0", extra); end
    $display("handshake: lat=%0d extra=%0d", lat, extra);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    issue(1'b0, 32'd100, 32'd200);
    wait_done(1, 0, 0, lat, bc);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    n_checks++;
    if (lo !== 32'd20000 || hi !== 32'd0) begin n_fail++; $display("FAIL b2b_first: got %h_%h, required 00004e20", hi, lo); end
    wait_done(1, 0, 0, lat, bc);
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d, required 34", lat); end
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL b2b_second: got %h_%h, required 00000001_00000000", hi, lo); end
    $display("back-to-back second -> %h_%h lat=%0d", hi, lo, lat);
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo;
    int lat, bc;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    n_checks++;
    if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi: got %h, required 12345678", hi); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done: got %b, required 0", done); end
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0000_0055;
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b0;
    n_checks++;
    if (hi !== 32'h55 || lo !== 32'h55) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h_%h, required 00000055_00000055", hi, lo); end
    $display("mthi/mtlo -> %h_%h", hi, lo);
    // Write coinciding with accepted start lands now, then gets overwritten.
    hi_we = 1'b1; wdata = 32'hAAAA_0000;
    issue(1'b0, 32'd7, 32'd6);
    hi_we = 1'b0;
    n_checks++;
    if (hi !== 32'hAAAA_0000) begin n_fail++; $display("FAIL mthi_with_start: got %h, required aaaa0000", hi); end
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    n_checks++;
    if (lo !== 32'h55) begin n_fail++; $display("FAIL mtlo_busy: got %h, required 00000055", lo); end
    wait_done(2, 0, 0, lat, bc);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL mtlo_overwrite: got %h_%h, required 00000000_0000002a", hi, lo); end
    $display("multu 7 x 6 after writes -> %h_%h", hi, lo);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int lat, bc, seen;
    issue(1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_no_done: %0d done pulses, required 0", seen); end
    issue(1'b0, 32'd7, 32'd6);
    wait_done(1, 0, 0, lat, bc);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL reset_then_mult: got %h_%h, required 00000000_0000002a", hi, lo); end
    $display("reset mid-op then multu 7 x 6 -> %h_%h", hi, lo);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    op_a = '0; op_b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk);
    test_reset;
    test_unsigned_max;
    test_signed;
    test_handshake;
    test_back_to_back;
    test_mthi_mtlo;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
# mult_unit

Multi-cycle 32x32 integer multiplier for the MIPS core's HI/LO path, serving `mult` and `multu`. It sits directly downstream of the 32-bit ripple adder: every shift-add step feeds the adder and consumes its sum and carry-out to build the 64-bit product. The block owns the architectural HI and LO registers. It also accepts `mthi`/`mtlo` writes, so the execute stage can stall on `busy` and read results after `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the product is `2*WIDTH` bits.

Ports:
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `start` in 1: request a multiply. Accepted only in IDLE.
- `is_signed` in 1: 1 selects `mult` (two's complement); 0 selects `multu`. Sampled with `start`.
- `op_a` in 32: multiplicand (rs), sampled with `start`.
- `op_b` in 32: multiplier (rt), sampled with `start`.
- `hi_we` in 1: `mthi` write strobe.
- `lo_we` in 1: `mtlo` write strobe.
- `wdata` in 32: data for `hi_we`/`lo_we`.
- `busy` out 1: high while a multiply is in flight (RUN or FIX).
- `done` out 1: one-cycle pulse when new HI/LO values become visible.
- `hi` out 32: HI register (product bits 63:32).
- `lo` out 32: LO register (product bits 31:0).

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE, sets `hi`=`lo`=0, `busy`=0, `done`=0, and clears the step counter and product register `P[63:0]`.
- IDLE with `start`=1:
  - Latch `neg` = `is_signed & (op_a[31] ^ op_b[31])`.
  - Latch `|A|` and `|B|`, where |x| means the two's complement negation of x when `is_signed` and x[31]=1, otherwise x unchanged. 0x80000000 maps to 0x80000000 (unsigned 2^31).
  - Set `P` = {32'h0, |B|}, step counter = 0, go to RUN.
- RUN, one step per cycle:
  - The adder instance computes `P[63:32] + |A|`, producing `sum[31:0]` and `carry`.
  - If `P[0]`=1: `P` <= {carry, sum, P[31:1]}. Otherwise `P` <= {1'b0, P[63:1]}.
  - The counter increments. After step 31, go to FIX.
- FIX:
  - If `neg`, the result is the 64-bit two's complement negation of `P`, which may use any adder logic. Otherwise the result is `P`.
  - Write the result to `hi`/`lo`, assert `done` for the next cycle, go to IDLE.
- Signed zero: a zero product with `neg`=1 negates to 0 and stays 0.
- `start` is ignored in RUN and FIX. No queuing.
- `hi_we`/`lo_we`:
  - In IDLE they write `wdata` to `hi`/`lo` on the edge. Both may be asserted together.
  - Ignored while `busy`.
  - If a write coincides with an accepted `start`, both take effect: the register is written now and overwritten when the multiply completes.
- `is_signed`, `op_a` and `op_b` are don't-care except in the cycle `start` is accepted.
- `hi`/`lo` hold their old values throughout RUN/FIX and change only on the FIX edge, on an mthi/mtlo write, or on reset.

## Timing
- `start` sampled at edge N. Then:
  - `busy`=1 during cycles N+1 .. N+33 (32 RUN cycles + 1 FIX cycle).
  - New `hi`/`lo` are visible in cycle N+34, and `done`=1 for exactly that cycle.
  - `busy`=0 in cycle N+34.
- A `start` during the `done` cycle is accepted, giving back-to-back issue every 34 cycles.
- `done` is never asserted by reset or by mthi/mtlo writes.
- `rst_n`=0 at any edge, including mid-RUN or FIX: the next cycle shows IDLE, `busy`=0, `done`=0, `hi`=`lo`=0. The in-flight result is discarded.
- Critical path is one 32-bit ripple add plus the shift mux per cycle. No combinational path runs from `start` to any output.

## Test plan
- Unsigned max: `multu` 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` exactly 34 cycles after the `start` edge, `busy` high for 33 cycles.
- Signed mixes:
  - `mult` -3 x 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - `mult` -1 x -1 -> `hi`=0, `lo`=1.
  - `mult` 0x80000000 x 0x80000000 -> `hi`=0x40000000, `lo`=0.
- Sign edge: `mult` 0x80000000 x 2 -> `hi`=0xFFFFFFFF, `lo`=0x00000000. `mult` 0 x -7 -> `hi`=`lo`=0.
- Handshake: `start` pulsed again at busy cycles 5 and 33 -> ignored, one `done` only. `start` in the `done` cycle -> second result 34 cycles later.
- mthi/mtlo: `hi_we` with 0x12345678 in IDLE -> `hi`=0x12345678 next cycle. `lo_we` during RUN -> `lo` unchanged until FIX result.
- Reset mid-op: `rst_n`=0 at RUN step 10 -> next cycle `busy`=0, `hi`=`lo`=0, no `done`. A fresh `multu` 7 x 6 then yields `lo`=42, `hi`=0.
